// File: rtl/pll_reset_sequencer.sv
// PLL lock qualifier and system reset sequencer for the iCE40 PLL clock domain.
// Ports: clk_i, reset_i (async, high), pll_lock_i (async), pll_resetb_o,
//   reset_o, ready_o, lock_loss_count_o[7:0]. Option: PLL_RESET_TIMEOUT_EN.
module pll_reset_sequencer #(
  parameter int SyncStages    = 2,
  parameter int LockCycles    = 1024,
  parameter int HoldCycles    = 16,
  parameter int TimeoutCycles = 65536
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       pll_lock_i,
  output logic       pll_resetb_o,
  output logic       reset_o,
  output logic       ready_o,
  output logic [7:0] lock_loss_count_o
);

  localparam int MaxLh =
    LockCycles > HoldCycles ? LockCycles : HoldCycles;
`ifdef PLL_RESET_TIMEOUT_EN
  // cnt doubles as the timeout and PLL_RST
  // duration counter, so it must reach 15.
  localparam int MaxTr =
    TimeoutCycles > 16 ? TimeoutCycles : 16;
`else
  localparam int MaxTr = TimeoutCycles;
`endif
  localparam int CntMax =
    MaxLh > MaxTr ? MaxLh : MaxTr;
  localparam int CntW =
    CntMax > 1 ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] LockLast =
    CntW'(LockCycles - 1);
  localparam logic [CntW-1:0] HoldLast =
    CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] CntOne =
    CntW'(1);
`ifdef PLL_RESET_TIMEOUT_EN
  localparam logic [CntW-1:0] TmoLast =
    CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] RstLast =
    CntW'(15);
`endif

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    HOLD      = 3'd2,
    RUN       = 3'd3
`ifdef PLL_RESET_TIMEOUT_EN
    ,
    PLL_RST   = 3'd4
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      llc_q, llc_d;
  logic [SyncStages-1:0] sync_q;
  logic            lock_sync;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0],
                 pll_lock_i};
    end
  end

  assign lock_sync = sync_q[SyncStages-1];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      llc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      llc_q   <= llc_d;
    end
  end

  // Every transition clears cnt so each state
  // starts counting from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    llc_d   = llc_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_sync) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
`ifdef PLL_RESET_TIMEOUT_EN
        else if (cnt_q == TmoLast) begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
`endif
      end
      STABLE: begin
        if (!lock_sync) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LockLast) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      HOLD: begin
        if (!lock_sync) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      RUN: begin
        if (!lock_sync) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          if (llc_q != 8'hff) begin
            llc_d = llc_q + 8'd1;
          end
        end
      end
`ifdef PLL_RESET_TIMEOUT_EN
      PLL_RST: begin
        if (cnt_q == RstLast) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
`endif
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  assign reset_o = (state_q != RUN);
  assign ready_o = (state_q == RUN);
  assign lock_loss_count_o = llc_q;

`ifdef PLL_RESET_TIMEOUT_EN
  assign pll_resetb_o = (state_q != PLL_RST);
`else
  assign pll_resetb_o = 1'b1;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the iCE40 PLL primitive and runs in the PLL output clock domain.
- Synchronises the PLL's asynchronous lock indication and requires lock to stay high for a qualification window.
- Then holds system reset for a further fixed window before releasing it.
- On lock loss it re-asserts system reset immediately and counts the event.

Parameters:
- SyncStages, 2, number of flops in the lock synchroniser (min 2).
- LockCycles, 1024, consecutive synchronised-lock cycles required before leaving STABLE (min 1).
- HoldCycles, 16, cycles reset is held after lock qualifies (min 1).
- TimeoutCycles, 65536, WAIT_LOCK cycles before a PLL reset retry; used only with PLL_RESET_TIMEOUT_EN.

Ports:
- clk_i, input, 1, PLL output clock; the only clock.
- reset_i, input, 1, asynchronous active-high reset.
- pll_lock_i, input, 1, raw PLL LOCK; asynchronous to clk_i.
- pll_resetb_o, output, 1, active-low PLL reset, to the PLL RESETB pin.
- reset_o, output, 1, active-high system reset for downstream logic; asserts asynchronously, deasserts synchronously.
- ready_o, output, 1, high only in RUN.
- lock_loss_count_o, output, 8, saturating count of lock losses seen in RUN.

Behaviour:

Reset and synchroniser
- One clock (clk_i); reset_i is asynchronous and active-high.
- While reset_i=1: state=WAIT_LOCK, all counters 0, synchroniser flops 0, reset_o=1, ready_o=0, pll_resetb_o=1, lock_loss_count_o=0.
- reset_i asserted mid-operation forces reset_o=1 and ready_o=0 immediately (asynchronously).
- lock_sync is pll_lock_i after SyncStages rising edges; it is the only lock signal the FSM uses.
- reset_o = (state != RUN) and ready_o = (state == RUN), both decoded from the registered state, with no further pipeline.

States: WAIT_LOCK, STABLE, HOLD, RUN; PLL_RST exists only with the macro.
- WAIT_LOCK: if lock_sync=1, go to STABLE and clear cnt.
- STABLE: if lock_sync=0, go to WAIT_LOCK. Else if cnt==LockCycles-1, go to HOLD and clear cnt. Else cnt++.
- HOLD: if lock_sync=0, go to WAIT_LOCK. Else if cnt==HoldCycles-1, go to RUN and clear cnt. Else cnt++.
- RUN: if lock_sync=0, go to WAIT_LOCK and increment lock_loss_count_o. The increment saturates at 255 and never wraps.
- A lock drop always takes priority over counter completion in the same cycle.

Timing and widths
- Latency: pll_lock_i rising (stable) → reset_o falls after SyncStages+1+LockCycles+HoldCycles rising edges.
- Lock loss in RUN: reset_o rises SyncStages+1 edges after pll_lock_i falls.
- Glitches shorter than LockCycles in STABLE, or dropouts during HOLD, restart qualification from WAIT_LOCK.
- cnt width is clog2 of max(LockCycles, HoldCycles, TimeoutCycles), min 1 bit.

Optional Feature:
- Macro: PLL_RESET_TIMEOUT_EN.
- Defined:
  - A timeout counter increments each cycle in WAIT_LOCK and clears on leaving WAIT_LOCK.
  - At TimeoutCycles-1 the FSM enters PLL_RST with pll_resetb_o=0 for exactly 16 cycles.
  - It then returns to WAIT_LOCK with the timeout counter at 0.
  - reset_o=1 and ready_o=0 throughout PLL_RST.
  - lock_sync is ignored in PLL_RST.
- Not defined: PLL_RST and the timeout counter are absent; pll_resetb_o is constant 1; TimeoutCycles is unused.

Test Plan:
Bench parameters: SyncStages=2, LockCycles=8, HoldCycles=4, TimeoutCycles=32.
1. Power-up: reset_i=1 for 3 cycles, pll_lock_i=0 → reset_o=1, ready_o=0, pll_resetb_o=1, lock_loss_count_o=0. Release reset_i with lock low for 20 cycles → outputs unchanged.
2. Clean lock: pll_lock_i→1 and held → reset_o falls and ready_o rises exactly 15 edges later; both stay stable for 100 cycles.
3. Glitch during qualification: lock high 5 cycles, low 1 cycle, high again → reset_o stays 1. Release occurs 15 edges after the final rise.
4. Lock loss in RUN: drop pll_lock_i → reset_o=1 within 3 edges and lock_loss_count_o 0→1. Relock → release 15 edges later. Repeat 300 losses → count saturates at 255.
5. Async reset mid-HOLD: assert reset_i → reset_o=1 with no clock edge, and FSM is in WAIT_LOCK after release. With lock still high, release occurs 15 edges after reset_i falls.
6. With PLL_RESET_TIMEOUT_EN and lock held 0: pll_resetb_o goes low after 32 WAIT_LOCK cycles for exactly 16 cycles, then the cycle repeats. Without the macro: pll_resetb_o stays 1 forever.
